// File: rtl/oam_dma_ctrl_if.sv
// OAM DMA control/bus bundle: start request from the FF46 decode, status back to the
// arbiter, and the read/write port set of the memory the DMA drives.
interface oam_dma_ctrl_if;
    logic        start;
    logic [7:0]  src_page;
    logic        busy;
    logic        done;
    logic [15:0] mem_r_addr;
    logic [7:0]  mem_r_data;
    logic        mem_wen;
    logic [15:0] mem_w_addr;
    logic [7:0]  mem_w_data;

    // DMA engine side
    modport master (
        input  start, src_page, mem_r_data,
        output busy, done, mem_r_addr, mem_wen, mem_w_addr, mem_w_data
    );

    // CPU decode / arbiter / memory side
    modport slave (
        output start, src_page, mem_r_data,
        input  busy, done, mem_r_addr, mem_wen, mem_w_addr, mem_w_data
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM-style DMA: copies LENGTH bytes from {src_page,8'h00} to DST_BASE, one byte per
// CYCLES_PER_BYTE clocks. All outputs are registered.
module oam_dma_ctrl #(
    parameter int unsigned LENGTH          = 160,
    parameter logic [15:0] DST_BASE        = 16'hFE00,
    parameter int unsigned CYCLES_PER_BYTE = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    oam_dma_ctrl_if.master bus
);
    localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0] PH_LAST = PW'(CYCLES_PER_BYTE - 1);
    // Write strobe is registered, so it is armed one phase before the slot's last cycle
    localparam logic [PW-1:0] PH_WEN  = PW'(CYCLES_PER_BYTE - 2);
    localparam logic [8:0]    IDX_LAST = 9'(LENGTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]    state_q,  state_d;
    logic [7:0]    page_q,   page_d;
    logic [8:0]    idx_q,    idx_d;
    logic [PW-1:0] phase_q,  phase_d;
    logic [7:0]    data_q,   data_d;
    logic [15:0]   r_addr_q, r_addr_d;
    logic          wen_q,    wen_d;
    logic [15:0]   w_addr_q, w_addr_d;
    logic [7:0]    w_data_q, w_data_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    // Next-state: start (re)launches from any state; otherwise walk phases/bytes in XFER
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        data_d   = data_q;
        r_addr_d = r_addr_q;
        wen_d    = 1'b0;
        w_addr_d = '0;
        w_data_d = '0;
        done_d   = 1'b0;
        if (bus.start) begin
            state_d  = ST_XFER;
            page_d   = bus.src_page;
            idx_d    = '0;
            phase_d  = '0;
            r_addr_d = {bus.src_page, 8'h00};
        end else if (state_q == ST_XFER) begin
            if (phase_q == '0) begin
                data_d = bus.mem_r_data;
            end
            if (phase_q == PH_WEN) begin
                wen_d    = 1'b1;
                w_addr_d = DST_BASE + {7'b0, idx_q};
                // With two clocks per byte the capture and arm phases coincide
                w_data_d = (phase_q == '0) ? bus.mem_r_data : data_q;
            end
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    r_addr_d = '0;
                    done_d   = 1'b1;
                end else begin
                    idx_d    = idx_q + 9'd1;
                    r_addr_d = {page_q, idx_q[7:0] + 8'd1};
                end
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end else begin
            r_addr_d = '0;
        end
        busy_d = (state_d == ST_XFER);
    end

    // State and output registers; reset overrides start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            data_q   <= '0;
            r_addr_q <= '0;
            wen_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
            r_addr_q <= r_addr_d;
            wen_q    <= wen_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_r_addr = r_addr_q;
    assign bus.mem_wen    = wen_q;
    assign bus.mem_w_addr = w_addr_q;
    assign bus.mem_w_data = w_data_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: two instances (default parameters, and CPB=2/LENGTH=256/
// DST_BASE=FFC0) each driving its own 64 KiB memory; results are compared to a byte-copy
// reference image of each memory.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_ctrl_if bus0();
    oam_dma_ctrl_if bus1();

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];
    logic [7:0] m0   [0:65535];
    logic [7:0] m1   [0:65535];

    assign bus0.mem_r_data = mem0[bus0.mem_r_addr];
    assign bus1.mem_r_data = mem1[bus1.mem_r_addr];

    oam_dma_ctrl #(.LENGTH(160), .DST_BASE(16'hFE00), .CYCLES_PER_BYTE(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0)
    );
    oam_dma_ctrl #(.LENGTH(256), .DST_BASE(16'hFFC0), .CYCLES_PER_BYTE(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int wen0 = 0, done0 = 0, busy0 = 0;
    int wen1 = 0, done1 = 0, busy1 = 0;
    int low_ff = 0, hi_pre = 0;
    bit chk_ff = 1'b0, watch_hi = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit the current cycle's write (memory writes on the coming edge), advance one
    // clock, then sample the new cycle's outputs.
    task automatic step();
        if (bus0.mem_wen === 1'b1) mem0[bus0.mem_w_addr] = bus0.mem_w_data;
        if (bus1.mem_wen === 1'b1) mem1[bus1.mem_w_addr] = bus1.mem_w_data;
        @(posedge clk);
        #1;
        if (bus0.mem_wen === 1'b1) wen0++;
        if (bus0.done === 1'b1) done0++;
        if (bus0.busy === 1'b1) busy0++;
        if (bus1.mem_wen === 1'b1) wen1++;
        if (bus1.done === 1'b1) done1++;
        if (bus1.busy === 1'b1) busy1++;
        if (chk_ff && bus0.busy === 1'b1 && bus0.mem_r_addr < 16'hFF00) low_ff++;
        if (watch_hi && bus0.mem_wen === 1'b1 && bus0.mem_w_addr >= 16'hFE32) hi_pre++;
    endtask

    task automatic model0(input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) m0[16'hFE00 + 16'(i)] = m0[{page, 8'(i)}];
    endtask

    task automatic model1(input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) m1[16'(32'hFFC0 + i)] = m1[{page, 8'(i)}];
    endtask

    task automatic cmp_mem0(input string tag);
        int bad = 0;
        for (int a = 0; a < 65536; a++) if (mem0[a] !== m0[a]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic cmp_mem1(input string tag);
        int bad = 0;
        for (int a = 0; a < 65536; a++) if (mem1[a] !== m1[a]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic start0(input logic [7:0] page);
        bus0.start = 1'b1;
        bus0.src_page = page;
        step();
        bus0.start = 1'b0;
    endtask

    task automatic wait_idle0(input string tag);
        int c = 0;
        while (bus0.busy === 1'b1 && c < 3000) begin step(); c++; end
        chk({tag, "_idle"}, bus0.busy, 1'b0);
        chk({tag, "_done_at_idle"}, bus0.done, 1'b1);
    endtask

    task automatic wait_raddr0(input string tag, input logic [15:0] a);
        int c = 0;
        while (bus0.mem_r_addr !== a && c < 3000) begin step(); c++; end
        chk({tag, "_reach_raddr"}, bus0.mem_r_addr, a);
    endtask

    initial begin
        int w, d, b, c;
        logic [7:0] p1, p2;
        int r;

        rst = 1'b1;
        bus0.start = 1'b1; bus0.src_page = 8'h12;
        bus1.start = 1'b1; bus1.src_page = 8'h40;
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 8'($urandom);
            mem1[a] = 8'($urandom);
        end
        for (int i = 0; i < 256; i++) begin
            mem0[16'h1200 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem0[16'hFF00 + 16'(i)] = ~8'(i);
        end
        for (int i = 0; i < 160; i++) mem0[16'hFE00 + 16'(i)] = 8'h00;
        for (int a = 0; a < 65536; a++) begin
            m0[a] = mem0[a];
            m1[a] = mem1[a];
        end

        // 1: reset held with start asserted
        repeat (3) begin
            step();
            chk("rst_busy", bus0.busy, 1'b0);
            chk("rst_done", bus0.done, 1'b0);
            chk("rst_wen", bus0.mem_wen, 1'b0);
            chk("rst_raddr", bus0.mem_r_addr, 16'h0);
            chk("rst_waddr", {bus0.mem_w_addr, bus0.mem_w_data}, 24'h0);
            chk("rst_busy1", bus1.busy, 1'b0);
        end
        rst = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        step();
        chk("idle_busy", bus0.busy, 1'b0);

        // 2: plain transfer from page 0x12
        w = wen0; d = done0; b = busy0;
        start0(8'h12);
        chk("t2_busy_rise", bus0.busy, 1'b1);
        chk("t2_raddr0", bus0.mem_r_addr, 16'h1200);
        wait_idle0("t2");
        chk("t2_wen_zero_at_idle", bus0.mem_wen, 1'b0);
        step();
        chk("t2_done_cleared", bus0.done, 1'b0);
        repeat (3) step();
        chk("t2_wen_count", wen0 - w, 160);
        chk("t2_busy_cycles", busy0 - b, 640);
        chk("t2_done_count", done0 - d, 1);
        model0(8'h12, 160);
        cmp_mem0("t2_mem");

        // 3: restart to page 0x34 at idx 50
        w = wen0; d = done0; b = busy0; hi_pre = 0;
        watch_hi = 1'b1;
        start0(8'h12);
        wait_raddr0("t3", 16'h1232);
        watch_hi = 1'b0;
        start0(8'h34);
        chk("t3_raddr_restart", bus0.mem_r_addr, 16'h3400);
        wait_idle0("t3");
        repeat (3) step();
        chk("t3_wen_count", wen0 - w, 50 + 160);
        chk("t3_busy_cycles", busy0 - b, 50 * 4 + 1 + 640);
        chk("t3_done_count", done0 - d, 1);
        chk("t3_hi_before_restart", hi_pre, 0);
        model0(8'h12, 50);
        model0(8'h34, 160);
        cmp_mem0("t3_mem");

        // 4: reset mid-transfer at idx 20
        for (int i = 0; i < 160; i++) begin
            mem0[16'hFE00 + 16'(i)] = 8'hEE;
            m0[16'hFE00 + 16'(i)] = 8'hEE;
        end
        w = wen0; d = done0;
        start0(8'h12);
        wait_raddr0("t4", 16'h1214);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_busy_after_rst", bus0.busy, 1'b0);
        chk("t4_wen_after_rst", bus0.mem_wen, 1'b0);
        repeat (60) step();
        chk("t4_wen_count", wen0 - w, 20);
        chk("t4_done_count", done0 - d, 0);
        model0(8'h12, 20);
        cmp_mem0("t4_mem");

        // 5: page 0xFF must not wrap to 0x00xx
        w = wen0; low_ff = 0;
        chk_ff = 1'b1;
        start0(8'hFF);
        wait_idle0("t5");
        chk_ff = 1'b0;
        repeat (2) step();
        chk("t5_low_raddr", low_ff, 0);
        chk("t5_wen_count", wen0 - w, 160);
        model0(8'hFF, 160);
        cmp_mem0("t5_mem");

        // Start coinciding with the final write: write lands, no done, new copy follows
        w = wen0; d = done0; b = busy0;
        start0(8'h12);
        c = 0;
        while (!(bus0.mem_wen === 1'b1 && bus0.mem_w_addr === 16'hFE9F) && c < 3000) begin
            step(); c++;
        end
        chk("tf_final_write_seen", bus0.mem_w_addr, 16'hFE9F);
        start0(8'h34);
        chk("tf_no_done", bus0.done, 1'b0);
        chk("tf_busy_held", bus0.busy, 1'b1);
        wait_idle0("tf");
        repeat (2) step();
        chk("tf_wen_count", wen0 - w, 320);
        chk("tf_busy_cycles", busy0 - b, 1280);
        chk("tf_done_count", done0 - d, 1);
        model0(8'h12, 160);
        model0(8'h34, 160);
        cmp_mem0("tf_mem");

        // Randomized restart points and pages
        repeat (3) begin
            p1 = 8'($urandom_range(8'h20, 8'hEF));
            p2 = 8'($urandom_range(8'h20, 8'hEF));
            r = int'($urandom_range(1, 159));
            w = wen0; d = done0; b = busy0;
            start0(p1);
            wait_raddr0("tr", {p1, 8'(r)});
            start0(p2);
            wait_idle0("tr");
            repeat (2) step();
            chk("tr_wen_count", wen0 - w, r + 160);
            chk("tr_busy_cycles", busy0 - b, r * 4 + 1 + 640);
            chk("tr_done_count", done0 - d, 1);
            model0(p1, r);
            model0(p2, 160);
            cmp_mem0("tr_mem");
        end

        // 6: CPB=2, LENGTH=256, destination wraps past FFFF
        w = wen1; d = done1; b = busy1;
        bus1.start = 1'b1;
        bus1.src_page = 8'h40;
        step();
        bus1.start = 1'b0;
        chk("t6_raddr0", bus1.mem_r_addr, 16'h4000);
        c = 0;
        while (bus1.busy === 1'b1 && c < 3000) begin step(); c++; end
        chk("t6_idle", bus1.busy, 1'b0);
        chk("t6_done_at_idle", bus1.done, 1'b1);
        repeat (2) step();
        chk("t6_wen_count", wen1 - w, 256);
        chk("t6_busy_cycles", busy1 - b, 512);
        chk("t6_done_count", done1 - d, 1);
        model1(8'h40, 256);
        cmp_mem1("t6_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
